updown_counter_n: RTL and testbench

UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

---
 rtl/udcnt_pkg.sv | 11 +
 rtl/udcnt_step.sv | 52 +++++
 rtl/updown_counter_n.sv | 115 +++++++++++
 tb/tb_updown_counter_n.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/udcnt_pkg.sv
// Shared types and constants for the up/down counter slice.
package udcnt_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } udcnt_mode_e;

    localparam int WRAP_CNT_W = 8;

endpackage

// File: rtl/udcnt_step.sv
// Combinational next-count computation with wrap/saturate and ovf/unf detection.
module udcnt_step
    import udcnt_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP    = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  udcnt_mode_e      mode,
    output logic [WIDTH-1:0] next,
    output logic             ovf_n,
    output logic             unf_n
);

    localparam longint unsigned MAX_P1_L = MAX_VAL + 64'd1;
    localparam logic [WIDTH:0]  MAX_W    = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH:0]  STEP_W   = STEP[WIDTH:0];
    localparam logic [WIDTH:0]  MAX_P1   = MAX_P1_L[WIDTH:0];

    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;

    always_comb begin
        up_sum  = {1'b0, count} + STEP_W;
        dn_diff = {1'b0, count} - STEP_W;
        next    = count;
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
        if (dir) begin
            if (up_sum > MAX_W) begin
                ovf_n = 1'b1;
                // Wrapped result is below STEP, so WIDTH-bit modular arithmetic is exact.
                next  = (mode == MODE_SAT) ? MAX_W[WIDTH-1:0]
                                           : up_sum[WIDTH-1:0] - MAX_P1[WIDTH-1:0];
            end else begin
                next = up_sum[WIDTH-1:0];
            end
        end else begin
            // Top bit of the extended difference is the borrow out of zero.
            if (dn_diff[WIDTH]) begin
                unf_n = 1'b1;
                next  = (mode == MODE_SAT) ? '0
                                           : dn_diff[WIDTH-1:0] + MAX_P1[WIDTH-1:0];
            end else begin
                next = dn_diff[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parameterised up/down counter with load, wrap or saturate mode and ovf/unf pulses.
// Optional wrap-event counter output enabled by macro UDCNT_WRAP_COUNT_EN.
module updown_counter_n
    import udcnt_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP    = 1,
    parameter udcnt_mode_e     MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
`ifdef UDCNT_WRAP_COUNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "updown_counter_n: WIDTH out of range 2..32");
    end
    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $fatal(1, "updown_counter_n: MAX_VAL out of range 1..2**WIDTH-1");
    end
    if (STEP < 64'd1 || STEP > MAX_VAL) begin : g_bad_step
        $fatal(1, "updown_counter_n: STEP out of range 1..MAX_VAL");
    end

    localparam logic [WIDTH:0] MAX_W = MAX_VAL[WIDTH:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] step_next;
    logic             step_ovf, step_unf;

    udcnt_step #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP    (STEP)
    ) u_step (
        .count (count_q),
        .dir   (increment),
        .mode  (MODE),
        .next  (step_next),
        .ovf_n (step_ovf),
        .unf_n (step_unf)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = ({1'b0, load_val} > MAX_W) ? MAX_W[WIDTH-1:0] : load_val;
        end else if (en && (increment != decrement)) begin
            count_d = step_next;
            ovf_d   = step_ovf;
            unf_d   = step_unf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count  = count_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign at_max = (count_q == MAX_W[WIDTH-1:0]);
    assign at_min = (count_q == '0);

`ifdef UDCNT_WRAP_COUNT_EN
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // Advances with the pulse being registered, so it already includes that pulse.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (load) begin
            wrap_cnt_d = '0;
        end else if ((ovf_d || unf_d) && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench driving three counter configurations (wrap, sat MAX 9, wrap STEP 3 MAX 9) in lockstep.
module tb_updown_counter_n;
    import udcnt_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        int cnt;
        bit o;
        bit u;
        int wc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en, increment, decrement, load;
    logic [3:0] load_val;
    logic [3:0] dcount [NDUT];
    logic       dmax   [NDUT];
    logic       dmin   [NDUT];
    logic       dovf   [NDUT];
    logic       dunf   [NDUT];
`ifdef UDCNT_WRAP_COUNT_EN
    logic [7:0] dwc    [NDUT];
`endif

    int   maxv [NDUT] = '{15, 9, 9};
    int   stp  [NDUT] = '{1, 1, 3};
    bit   sat  [NDUT] = '{1'b0, 1'b1, 1'b0};
    int   m_cnt [NDUT];
    int   m_wc  [NDUT];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(4), .MAX_VAL(15), .STEP(1), .MODE(MODE_WRAP)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .increment(increment), .decrement(decrement),
        .load(load), .load_val(load_val), .count(dcount[0]), .at_max(dmax[0]),
        .at_min(dmin[0]), .ovf(dovf[0]), .unf(dunf[0])
`ifdef UDCNT_WRAP_COUNT_EN
        , .wrap_cnt(dwc[0])
`endif
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .MODE(MODE_SAT)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .increment(increment), .decrement(decrement),
        .load(load), .load_val(load_val), .count(dcount[1]), .at_max(dmax[1]),
        .at_min(dmin[1]), .ovf(dovf[1]), .unf(dunf[1])
`ifdef UDCNT_WRAP_COUNT_EN
        , .wrap_cnt(dwc[1])
`endif
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .MODE(MODE_WRAP)) u_dut_c (
        .clk(clk), .reset(reset), .en(en), .increment(increment), .decrement(decrement),
        .load(load), .load_val(load_val), .count(dcount[2]), .at_max(dmax[2]),
        .at_min(dmin[2]), .ovf(dovf[2]), .unf(dunf[2])
`ifdef UDCNT_WRAP_COUNT_EN
        , .wrap_cnt(dwc[2])
`endif
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, push the model's expectation, then pop and compare after the edge.
    task automatic cycle(input bit r, input bit ld, input int lv, input bit e, input bit i, input bit d);
        exp_t x;
        int   s;
        reset     = r;
        load      = ld;
        load_val  = lv[3:0];
        en        = e;
        increment = i;
        decrement = d;
        for (int k = 0; k < NDUT; k++) begin
            x.o = 1'b0;
            x.u = 1'b0;
            if (r) begin
                m_cnt[k] = 0;
                m_wc[k]  = 0;
            end else if (ld) begin
                m_cnt[k] = (lv[3:0] > maxv[k]) ? maxv[k] : int'(lv[3:0]);
                m_wc[k]  = 0;
            end else if (e && (i != d)) begin
                if (i) begin
                    s   = m_cnt[k] + stp[k];
                    x.o = (s > maxv[k]);
                    m_cnt[k] = sat[k] ? ((s > maxv[k]) ? maxv[k] : s) : s % (maxv[k] + 1);
                end else begin
                    s   = m_cnt[k] - stp[k];
                    x.u = (s < 0);
                    m_cnt[k] = sat[k] ? ((s < 0) ? 0 : s) : (s + maxv[k] + 1) % (maxv[k] + 1);
                end
                if ((x.o || x.u) && m_wc[k] < 255) m_wc[k]++;
            end
            x.cnt = m_cnt[k];
            x.wc  = m_wc[k];
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                x = exp_q.pop_front();
                check($sformatf("count[%0d]", k), dcount[k], x.cnt);
                check($sformatf("ovf[%0d]", k), dovf[k], x.o);
                check($sformatf("unf[%0d]", k), dunf[k], x.u);
                check($sformatf("at_max[%0d]", k), dmax[k], x.cnt == maxv[k]);
                check($sformatf("at_min[%0d]", k), dmin[k], x.cnt == 0);
`ifdef UDCNT_WRAP_COUNT_EN
                check($sformatf("wrap_cnt[%0d]", k), dwc[k], x.wc);
`endif
            end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; increment = 1'b0; decrement = 1'b0;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0);
        // Load above MAX_VAL clips to 9 on the MAX 9 instances.
        cycle(0, 1, 12, 1, 0, 0);
        cycle(0, 1, 15, 0, 0, 0);
        // 15 -> 0 with ovf on the full-range wrap; SAT instance stays pinned at 9 with ovf each cycle.
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        // Step 3 from 1 wraps to 8 with unf.
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        // Both requests or en low hold with no pulses; load ignores en.
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 1, 9, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        // Reset beats a coincident load and step.
        cycle(1, 1, 7, 1, 1, 0);
        cycle(0, 0, 0, 1, 0, 1);
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 11) == 0),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // 300 clipped steps on the SAT instance drive the wrap counter to its 255 ceiling.
        cycle(0, 1, 9, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            cycle(0, 0, 0, 1, 1, 0);
        end
        cycle(0, 1, 3, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
